// File: rtl/float_classify_stream_pkg.sv
// Shared class encoding for the streaming float classifier and its counters.
package float_classify_stream_pkg;

  localparam int NUM_CLS  = 5;
  localparam int CLS_ZERO = 0;
  localparam int CLS_NORM = 1;
  localparam int CLS_SUB  = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_NAN  = 4;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_NORM = 3'd1,
    SEL_SUB  = 3'd2,
    SEL_INF  = 3'd3,
    SEL_NAN  = 3'd4
  } cnt_sel_e;

endpackage

// File: rtl/float_class_comb.sv
// Purely combinational IEEE-754-style classifier: one-hot class, sign and signalling-NaN flag.
module float_class_comb
  import float_classify_stream_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] num_i,
  output logic [NUM_CLS-1:0]   type_o,
  output logic                 sign_o,
  output logic                 snan_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_zero;
  logic             exp_ones;
  logic             man_zero;

  assign exp_f    = num_i[EXP_W+MAN_W-1 -: EXP_W];
  assign man_f    = num_i[MAN_W-1:0];
  assign exp_zero = (exp_f == '0);
  assign exp_ones = &exp_f;
  assign man_zero = (man_f == '0);
  assign sign_o   = num_i[EXP_W+MAN_W];

  always_comb begin
    type_o = '0;
    if (exp_zero && man_zero)      type_o[CLS_ZERO] = 1'b1;
    else if (exp_zero)             type_o[CLS_SUB]  = 1'b1;
    else if (exp_ones && man_zero) type_o[CLS_INF]  = 1'b1;
    else if (exp_ones)             type_o[CLS_NAN]  = 1'b1;
    else                           type_o[CLS_NORM] = 1'b1;
  end

  // Quiet NaNs carry the mantissa MSB set; a clear MSB marks a signalling NaN.
  assign snan_o = exp_ones && !man_zero && !man_f[MAN_W-1];

endmodule

// File: rtl/float_classify_stream.sv
// Streaming float classifier: one-deep ready/valid output register plus saturating per-class counters.
module float_classify_stream
  import float_classify_stream_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_num,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_CLS-1:0]   out_type,
  output logic                 out_sign,
  output logic                 out_snan,
  input  logic                 clear_cnt,
  input  logic [2:0]           cnt_sel,
  output logic [CNT_W-1:0]     cnt_val
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CLS-1:0] cls_type;
  logic               cls_sign;
  logic               cls_snan;
  logic               accept;

  logic               valid_q, valid_d;
  logic [NUM_CLS-1:0] type_q;
  logic               sign_q;
  logic               snan_q;
  logic [CNT_W-1:0]   cnt_q [NUM_CLS];
  logic [CNT_W-1:0]   cnt_d [NUM_CLS];

  float_class_comb #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_class (
    .num_i  (in_num),
    .type_o (cls_type),
    .sign_o (cls_sign),
    .snan_o (cls_snan)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (accept)         valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    for (int i = 0; i < NUM_CLS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_cnt)
        cnt_d[i] = '0;
      else if (accept && cls_type[i] && (cnt_q[i] != CNT_MAX))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      type_q  <= '0;
      sign_q  <= 1'b0;
      snan_q  <= 1'b0;
      for (int i = 0; i < NUM_CLS; i++) cnt_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        type_q <= cls_type;
        sign_q <= cls_sign;
        snan_q <= cls_snan;
      end
      for (int i = 0; i < NUM_CLS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = valid_q;
  assign out_type  = type_q;
  assign out_sign  = sign_q;
  assign out_snan  = snan_q;

  always_comb begin
    cnt_val = '0;
    case (cnt_sel)
      SEL_ZERO: cnt_val = cnt_q[CLS_ZERO];
      SEL_NORM: cnt_val = cnt_q[CLS_NORM];
      SEL_SUB:  cnt_val = cnt_q[CLS_SUB];
      SEL_INF:  cnt_val = cnt_q[CLS_INF];
      SEL_NAN:  cnt_val = cnt_q[CLS_NAN];
      default:  cnt_val = '0;
    endcase
  end

endmodule

// File: tb/tb_float_classify_stream.sv
// Directed bench for float_classify_stream: binary32 stream, 4-bit counter saturation, binary16 instance.
module tb_float_classify_stream;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // binary32, 16-bit counters
  logic        m_reset, m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [31:0] m_in_num;
  logic [4:0]  m_out_type;
  logic        m_out_sign, m_out_snan, m_clear;
  logic [2:0]  m_sel;
  logic [15:0] m_cnt;

  // binary32, 4-bit counters
  logic        s_reset, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_num;
  logic [4:0]  s_out_type;
  logic        s_out_sign, s_out_snan, s_clear;
  logic [2:0]  s_sel;
  logic [3:0]  s_cnt;

  // binary16
  logic        h_reset, h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_in_num;
  logic [4:0]  h_out_type;
  logic        h_out_sign, h_out_snan, h_clear;
  logic [2:0]  h_sel;
  logic [15:0] h_cnt;

  float_classify_stream dut_m (
    .clk(clk), .reset(m_reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_num(m_in_num), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_type(m_out_type), .out_sign(m_out_sign), .out_snan(m_out_snan),
    .clear_cnt(m_clear), .cnt_sel(m_sel), .cnt_val(m_cnt)
  );

  float_classify_stream #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_num(s_in_num), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_type(s_out_type), .out_sign(s_out_sign), .out_snan(s_out_snan),
    .clear_cnt(s_clear), .cnt_sel(s_sel), .cnt_val(s_cnt)
  );

  float_classify_stream #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(h_reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_num(h_in_num), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_type(h_out_type), .out_sign(h_out_sign), .out_snan(h_out_snan),
    .clear_cnt(h_clear), .cnt_sel(h_sel), .cnt_val(h_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_cnt_chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    m_sel = sel;
    #1;
    check_eq(tag, {16'h0, m_cnt}, exp);
  endtask

  task automatic s_cnt_chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    s_sel = sel;
    #1;
    check_eq(tag, {28'h0, s_cnt}, exp);
  endtask

  logic [31:0] vec_num  [5] = '{32'h00000000, 32'h00000001, 32'h3F800000, 32'h7FC00000, 32'h7F800001};
  logic [4:0]  vec_type [5] = '{5'b00001, 5'b00100, 5'b00010, 5'b10000, 5'b10000};
  logic        vec_snan [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    m_reset = 1; m_in_valid = 0; m_in_num = '0; m_out_ready = 1; m_clear = 0; m_sel = 0;
    s_reset = 1; s_in_valid = 0; s_in_num = '0; s_out_ready = 1; s_clear = 0; s_sel = 0;
    h_reset = 1; h_in_valid = 0; h_in_num = '0; h_out_ready = 1; h_clear = 0; h_sel = 0;
    step(); step();
    m_reset = 0; s_reset = 0; h_reset = 0;
    step();

    // Reset state
    check_eq("rst_out_valid", {31'h0, m_out_valid}, 0);
    check_eq("rst_out_type",  {27'h0, m_out_type}, 0);
    check_eq("rst_out_sign",  {31'h0, m_out_sign}, 0);
    check_eq("rst_out_snan",  {31'h0, m_out_snan}, 0);
    check_eq("rst_in_ready",  {31'h0, m_in_ready}, 1);
    for (int i = 0; i < 5; i++) m_cnt_chk($sformatf("rst_cnt%0d", i), 3'(i), 0);

    // Test 1: negative infinity
    m_in_num = 32'hFF800000; m_in_valid = 1;
    step();
    m_in_valid = 0;
    check_eq("t1_valid", {31'h0, m_out_valid}, 1);
    check_eq("t1_type",  {27'h0, m_out_type}, 32'b01000);
    check_eq("t1_sign",  {31'h0, m_out_sign}, 1);
    check_eq("t1_snan",  {31'h0, m_out_snan}, 0);
    m_cnt_chk("t1_cnt_inf", 3'd3, 1);
    step();
    check_eq("t1_drain", {31'h0, m_out_valid}, 0);
    check_eq("t1_hold_type", {27'h0, m_out_type}, 32'b01000);

    // Test 2: back-to-back stream
    for (int i = 0; i < 5; i++) begin
      m_in_num = vec_num[i]; m_in_valid = 1;
      #1;
      check_eq($sformatf("t2_ready%0d", i), {31'h0, m_in_ready}, 1);
      step();
      check_eq($sformatf("t2_valid%0d", i), {31'h0, m_out_valid}, 1);
      check_eq($sformatf("t2_type%0d", i), {27'h0, m_out_type}, {27'h0, vec_type[i]});
      check_eq($sformatf("t2_snan%0d", i), {31'h0, m_out_snan}, {31'h0, vec_snan[i]});
    end
    m_in_valid = 0;
    step();
    m_cnt_chk("t2_cnt_zero", 3'd0, 1);
    m_cnt_chk("t2_cnt_norm", 3'd1, 1);
    m_cnt_chk("t2_cnt_sub",  3'd2, 1);
    m_cnt_chk("t2_cnt_inf",  3'd3, 1);
    m_cnt_chk("t2_cnt_nan",  3'd4, 2);

    // Test 3: backpressure
    m_out_ready = 0; m_in_num = 32'h40000000; m_in_valid = 1;
    step();
    check_eq("t3_valid", {31'h0, m_out_valid}, 1);
    check_eq("t3_type",  {27'h0, m_out_type}, 32'b00010);
    m_in_num = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t3_stall_ready%0d", i), {31'h0, m_in_ready}, 0);
      step();
      check_eq($sformatf("t3_stall_valid%0d", i), {31'h0, m_out_valid}, 1);
      check_eq($sformatf("t3_stall_type%0d", i), {27'h0, m_out_type}, 32'b00010);
      check_eq($sformatf("t3_stall_sign%0d", i), {31'h0, m_out_sign}, 0);
    end
    m_cnt_chk("t3_cnt_norm", 3'd1, 2);
    m_cnt_chk("t3_cnt_zero", 3'd0, 1);
    m_out_ready = 1;
    #1;
    check_eq("t3_release_ready", {31'h0, m_in_ready}, 1);
    step();
    m_in_valid = 0;
    check_eq("t3_next_type", {27'h0, m_out_type}, 32'b00001);
    check_eq("t3_next_sign", {31'h0, m_out_sign}, 1);
    m_cnt_chk("t3_cnt_zero2", 3'd0, 2);

    // Unused selects read 0 while counters are non-zero
    for (int i = 5; i < 8; i++) m_cnt_chk($sformatf("t6_sel%0d", i), 3'(i), 0);

    // Test 6: reset with a stalled result pending
    m_out_ready = 0; m_in_num = 32'h7F800000; m_in_valid = 1;
    step();
    check_eq("t6_pending", {31'h0, m_out_valid}, 1);
    m_reset = 1;
    step();
    step();
    m_reset = 0; m_in_valid = 0; m_out_ready = 1;
    check_eq("t6_valid", {31'h0, m_out_valid}, 0);
    for (int i = 0; i < 5; i++) m_cnt_chk($sformatf("t6_cnt%0d", i), 3'(i), 0);
    for (int i = 5; i < 8; i++) m_cnt_chk($sformatf("t6_rsel%0d", i), 3'(i), 0);

    // Test 4: saturation with 4-bit counters
    s_in_num = 32'h3F800000; s_in_valid = 1;
    step();
    s_in_num = 32'h00000000;
    for (int i = 0; i < 20; i++) step();
    s_in_valid = 0;
    s_cnt_chk("t4_sat_zero", 3'd0, 15);
    s_cnt_chk("t4_norm", 3'd1, 1);
    s_in_num = 32'h00000000; s_in_valid = 1; s_clear = 1;
    step();
    s_in_valid = 0; s_clear = 0;
    check_eq("t4_clr_valid", {31'h0, s_out_valid}, 1);
    check_eq("t4_clr_type",  {27'h0, s_out_type}, 32'b00001);
    for (int i = 0; i < 5; i++) s_cnt_chk($sformatf("t4_clr_cnt%0d", i), 3'(i), 0);

    // Test 5: binary16
    h_in_num = 16'h7C00; h_in_valid = 1;
    step();
    check_eq("t5_inf_type", {27'h0, h_out_type}, 32'b01000);
    h_in_num = 16'h0200;
    step();
    check_eq("t5_sub_type", {27'h0, h_out_type}, 32'b00100);
    h_in_num = 16'h7E00;
    step();
    check_eq("t5_qnan_type", {27'h0, h_out_type}, 32'b10000);
    check_eq("t5_qnan_snan", {31'h0, h_out_snan}, 0);
    h_in_num = 16'hFD00;
    step();
    h_in_valid = 0;
    check_eq("t5_snan_type", {27'h0, h_out_type}, 32'b10000);
    check_eq("t5_snan_snan", {31'h0, h_out_snan}, 1);
    check_eq("t5_snan_sign", {31'h0, h_out_sign}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
